mdu_unit: RTL and testbench

- Multiply/divide unit in the E stage of the 5-stage pipeline.
- Owns the HI/LO registers and executes MULT/MULTU/DIV/DIVU/MTHI/MTLO, with the MFHI/MFLO read path.
- Drives `start` and `busy` to the stall controller, which stalls any MDU-related instruction in D while `start | busy` is high.
- Models fixed multi-cycle latency.

---
 rtl/mdu_unit.sv | 115 +++++++++++
 tb/tb_mdu_unit.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_unit.sv
// mdu_unit: E-stage multiply/divide unit owning HI/LO; MADD/MADDU/MSUB enabled by `MDU_MADD_EN
module mdu_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [3:0]  mdu_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        start,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] mdu_out
);
  typedef enum logic {IDLE, CALC} state_t;
  state_t state, state_next;
  logic [3:0] count;
  logic [31:0] pending_hi, pending_lo;
  logic pending_we;
  logic is_mul, is_div, is_madd;
  logic [63:0] prod_s, prod_u;
  logic [31:0] b_div, qu, ru;
  logic [31:0] a_mag, b_mag, b_sdiv, qm, rm, qs, rs;
  logic [31:0] res_hi, res_lo;
  logic res_we;

  assign is_mul = (mdu_op == 4'd1) || (mdu_op == 4'd2);
  assign is_div = (mdu_op == 4'd3) || (mdu_op == 4'd4);
`ifdef MDU_MADD_EN
  assign is_madd = (mdu_op == 4'd9) || (mdu_op == 4'd10) || (mdu_op == 4'd11);
`else
  assign is_madd = 1'b0;
`endif
  assign start   = (state == IDLE) && (is_mul || is_div || is_madd);
  assign busy    = (state == CALC);
  assign mdu_out = (mdu_op == 4'd7) ? HI : (mdu_op == 4'd8) ? LO : 32'd0;

  assign prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
  assign prod_u = {32'd0, A} * {32'd0, B};
  // Divisors are forced non-zero so the datapath never divides by zero; a zero B suppresses the write instead
  assign b_div  = (B == 32'd0) ? 32'd1 : B;
  assign qu     = A / b_div;
  assign ru     = A % b_div;
  // Signed divide on magnitudes: 0x80000000 magnitude stays 0x80000000, giving the wrapped quotient for -2^31/-1
  assign a_mag  = A[31] ? -A : A;
  assign b_mag  = B[31] ? -B : B;
  assign b_sdiv = (b_mag == 32'd0) ? 32'd1 : b_mag;
  assign qm     = a_mag / b_sdiv;
  assign rm     = a_mag % b_sdiv;
  assign qs     = (A[31] ^ B[31]) ? -qm : qm;
  assign rs     = A[31] ? -rm : rm;

  // Result selection for the op being issued; captured into pending at the start edge
  always_comb begin
    res_we = 1'b1;
    {res_hi, res_lo} = prod_s;
    case (mdu_op)
      4'd2: {res_hi, res_lo} = prod_u;
      4'd3: begin
        {res_hi, res_lo} = {rs, qs};
        res_we = (B != 32'd0);
      end
      4'd4: begin
        {res_hi, res_lo} = {ru, qu};
        res_we = (B != 32'd0);
      end
`ifdef MDU_MADD_EN
      4'd9:  {res_hi, res_lo} = {HI, LO} + prod_s;
      4'd10: {res_hi, res_lo} = {HI, LO} + prod_u;
      4'd11: {res_hi, res_lo} = {HI, LO} - prod_s;
`endif
      default: ;
    endcase
  end

  // Next state: leave IDLE on start, return on the final countdown cycle
  always_comb begin
    state_next = state;
    state_next = (state == IDLE) ? (start ? CALC : IDLE) : ((count == 4'd1) ? IDLE : CALC);
  end

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else state <= state_next;
  end

  // Countdown, pending result and HI/LO updates
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      HI <= 32'd0;
      LO <= 32'd0;
      count <= 4'd0;
      pending_hi <= 32'd0;
      pending_lo <= 32'd0;
      pending_we <= 1'b0;
    end else if (state == IDLE) begin
      if (start) begin
        count <= is_div ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
        pending_hi <= res_hi;
        pending_lo <= res_lo;
        pending_we <= res_we;
      end else if (mdu_op == 4'd5) HI <= A;
      else if (mdu_op == 4'd6) LO <= A;
    end else begin
      count <= count - 4'd1;
      if (count == 4'd1 && pending_we) begin
        HI <= pending_hi;
        LO <= pending_lo;
      end
    end
  end
endmodule

// File: tb/tb_mdu_unit.sv
// tb_mdu_unit: directed bench for mdu_unit with a cycle-level reference model
module tb_mdu_unit;
  localparam int MC = 5;
  localparam int DC = 10;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [3:0] mdu_op = 4'd0;
  logic [31:0] A = 32'd0, B = 32'd0;
  logic start, busy;
  logic [31:0] HI, LO, mdu_out;

  int total = 0;
  int bad = 0;
  bit en = 1'b0;
  int n;

  logic [31:0] m_hi = 32'd0, m_lo = 32'd0;
  logic [64:0] p = '0;
  int m_rem = 0;

  mdu_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset_n(reset_n), .mdu_op(mdu_op), .A(A), .B(B),
    .start(start), .busy(busy), .HI(HI), .LO(LO), .mdu_out(mdu_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit computes(input logic [3:0] op);
`ifdef MDU_MADD_EN
    return (op >= 4'd1 && op <= 4'd4) || (op >= 4'd9 && op <= 4'd11);
`else
    return (op >= 4'd1 && op <= 4'd4);
`endif
  endfunction

  // Returns {write_enable, hi, lo} from plain integer arithmetic
  function automatic logic [64:0] calc(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic [63:0] acc);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint unsigned ua = {32'd0, a};
    longint unsigned ub = {32'd0, b};
    longint q, r;
    case (op)
      4'd1: return {1'b1, 64'(sa * sb)};
      4'd2: return {1'b1, ua * ub};
      4'd3: begin
        if (b == 32'd0) return '0;
        q = sa / sb;
        r = sa % sb;
        return {1'b1, r[31:0], q[31:0]};
      end
      4'd4: begin
        if (b == 32'd0) return '0;
        return {1'b1, a % b, a / b};
      end
      4'd9:  return {1'b1, acc + 64'(sa * sb)};
      4'd10: return {1'b1, acc + ua * ub};
      4'd11: return {1'b1, acc - 64'(sa * sb)};
      default: return '0;
    endcase
  endfunction

  // Reference model: idle ops act at once, computing ops land after their full latency
  always @(posedge clk) begin
    if (!reset_n) begin
      m_hi <= 32'd0;
      m_lo <= 32'd0;
      m_rem <= 0;
      p <= '0;
    end else if (m_rem != 0) begin
      m_rem <= m_rem - 1;
      if (m_rem == 1 && p[64]) begin
        m_hi <= p[63:32];
        m_lo <= p[31:0];
      end
    end else if (computes(mdu_op)) begin
      p <= calc(mdu_op, A, B, {m_hi, m_lo});
      m_rem <= (mdu_op == 4'd3 || mdu_op == 4'd4) ? DC : MC;
    end else if (mdu_op == 4'd5) m_hi <= A;
    else if (mdu_op == 4'd6) m_lo <= A;
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (en) begin
      chk("busy", {31'd0, busy}, {31'd0, m_rem != 0});
      chk("start", {31'd0, start}, {31'd0, m_rem == 0 && computes(mdu_op)});
      chk("hi", HI, m_hi);
      chk("lo", LO, m_lo);
      chk("mdu_out", mdu_out, mdu_op == 4'd7 ? m_hi : mdu_op == 4'd8 ? m_lo : 32'd0);
    end
  end

  task automatic idle(input int c);
    repeat (c) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic exp_start);
    mdu_op = op;
    A = a;
    B = b;
    #1 chk("issue_start", {31'd0, start}, {31'd0, exp_start});
    @(negedge clk);
    #1 mdu_op = 4'd0;
  endtask

  task automatic set_op(input logic [3:0] op, input logic [31:0] a);
    mdu_op = op;
    A = a;
    @(negedge clk);
    #1 mdu_op = 4'd0;
  endtask

  task automatic wait_done(output int cnt);
    cnt = 0;
    while (busy && cnt < 40) begin
      cnt++;
      @(negedge clk);
      #1;
    end
    if (cnt >= 40) chk("done_timeout", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    @(negedge clk);
    #1;
    idle(1);
    en = 1'b1;
    idle(1);
    reset_n = 1'b1;
    chk("rst_hi", HI, 32'd0);
    chk("rst_lo", LO, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);

    issue(4'd1, 32'hFFFFFFFF, 32'd2, 1'b1);
    wait_done(n);
    chk("mult_cycles", n, MC);
    chk("mult_hi", HI, 32'hFFFFFFFF);
    chk("mult_lo", LO, 32'hFFFFFFFE);

    issue(4'd2, 32'hFFFFFFFF, 32'd2, 1'b1);
    wait_done(n);
    chk("multu_cycles", n, MC);
    chk("multu_hi", HI, 32'h00000001);
    chk("multu_lo", LO, 32'hFFFFFFFE);

    issue(4'd3, 32'hFFFFFFF9, 32'd2, 1'b1);
    wait_done(n);
    chk("div_cycles", n, DC);
    chk("div_lo", LO, 32'hFFFFFFFD);
    chk("div_hi", HI, 32'hFFFFFFFF);

    issue(4'd4, 32'd7, 32'd2, 1'b1);
    wait_done(n);
    chk("divu_lo", LO, 32'd3);
    chk("divu_hi", HI, 32'd1);

    issue(4'd3, 32'd5, 32'd0, 1'b1);
    wait_done(n);
    chk("div0_cycles", n, DC);
    chk("div0_hi", HI, 32'd1);
    chk("div0_lo", LO, 32'd3);

    issue(4'd3, 32'h80000000, 32'hFFFFFFFF, 1'b1);
    wait_done(n);
    chk("divovf_lo", LO, 32'h80000000);
    chk("divovf_hi", HI, 32'd0);

    set_op(4'd5, 32'h12345678);
    mdu_op = 4'd7;
    #1 chk("mfhi", mdu_out, 32'h12345678);
    idle(1);
    set_op(4'd6, 32'hCAFEF00D);
    mdu_op = 4'd8;
    #1 chk("mflo", mdu_out, 32'hCAFEF00D);
    idle(1);
    mdu_op = 4'd0;

    issue(4'd1, 32'd3, 32'd5, 1'b1);
    set_op(4'd6, 32'hDEADBEEF);
    wait_done(n);
    chk("mtlo_busy_lo", LO, 32'd15);
    chk("mtlo_busy_hi", HI, 32'd0);

    issue(4'd2, 32'd10, 32'd10, 1'b1);
    issue(4'd4, 32'd100, 32'd7, 1'b0);
    wait_done(n);
    chk("b2b_lo", LO, 32'd100);
    chk("b2b_hi", HI, 32'd0);
    idle(3);
    chk("ignored_div_lo", LO, 32'd100);

    issue(4'd12, 32'd1, 32'd1, 1'b0);
    idle(2);
    chk("op12_busy", {31'd0, busy}, 32'd0);

`ifdef MDU_MADD_EN
    set_op(4'd5, 32'd0);
    set_op(4'd6, 32'hFFFFFFFF);
    issue(4'd10, 32'd1, 32'd1, 1'b1);
    wait_done(n);
    chk("maddu_cycles", n, MC);
    chk("maddu_hi", HI, 32'd1);
    chk("maddu_lo", LO, 32'd0);
    issue(4'd11, 32'd1, 32'd1, 1'b1);
    wait_done(n);
    chk("msub_hi", HI, 32'd0);
    chk("msub_lo", LO, 32'hFFFFFFFF);
    issue(4'd9, 32'hFFFFFFFF, 32'd2, 1'b1);
    wait_done(n);
    chk("madd_hi", HI, 32'd0);
    chk("madd_lo", LO, 32'hFFFFFFFD);
`else
    set_op(4'd5, 32'd5);
    set_op(4'd6, 32'd6);
    issue(4'd9, 32'd1, 32'd1, 1'b0);
    idle(MC + 1);
    chk("op9_hi", HI, 32'd5);
    chk("op9_lo", LO, 32'd6);
    chk("op9_busy", {31'd0, busy}, 32'd0);
`endif

    issue(4'd1, 32'd3, 32'd4, 1'b1);
    idle(1);
    reset_n = 1'b0;
    idle(2);
    reset_n = 1'b1;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_hi", HI, 32'd0);
    chk("midrst_lo", LO, 32'd0);
    idle(MC + 3);
    chk("midrst_lo_late", LO, 32'd0);
    chk("midrst_hi_late", HI, 32'd0);

    idle(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
